// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU interface: accepts one decoded operation at a time,
// holds registered operands/control on the ALU, and returns the captured result.
module alu_op_sequencer #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_aluop_i,
  input  logic [5:0]       req_funct_i,
  input  logic [WIDTH-1:0] req_src1_i,
  input  logic [WIDTH-1:0] req_src2_i,
  output logic [WIDTH-1:0] alu_src1_o,
  output logic [WIDTH-1:0] alu_src2_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_zero_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_zero_o,
  output logic             rsp_illegal_o,
  output logic [CNT_W-1:0] op_count_o
);

  localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [EW-1:0] CNT_LOAD = EW'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_ready;
  logic [EW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_src1;
  logic [WIDTH-1:0] r_src2;
  logic [3:0]       r_ctrl;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  logic [3:0]       w_dec_ctrl;
  logic             w_dec_illegal;
  logic             w_accept;
  logic             w_cnt_done;
  logic             w_rsp_done;

  // Undecodable requests still drive the add code so the ALU sees a defined operation.
  always_comb begin
    w_dec_ctrl    = 4'b0010;
    w_dec_illegal = 1'b0;
    case (req_aluop_i)
      2'b00: w_dec_ctrl = 4'b0010;
      2'b01: w_dec_ctrl = 4'b0110;
      2'b10: begin
        case (req_funct_i)
          6'b100000: w_dec_ctrl = 4'b0010;
          6'b100010: w_dec_ctrl = 4'b0110;
          6'b100100: w_dec_ctrl = 4'b0000;
          6'b100101: w_dec_ctrl = 4'b0001;
          6'b101010: w_dec_ctrl = 4'b0111;
          default:   w_dec_illegal = 1'b1;
        endcase
      end
      default: w_dec_illegal = 1'b1;
    endcase
  end

  assign w_accept   = req_valid_i & r_ready;
  assign w_cnt_done = (r_cnt == '0);
  assign w_rsp_done = (r_state == RESP) & rsp_ready_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_dec_illegal ? RESP : EXEC;
      EXEC:    if (w_cnt_done) w_next = RESP;
      RESP:    if (rsp_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Ready is registered so it stays low for the first clock after reset release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == IDLE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt     <= '0;
      r_src1    <= '0;
      r_src2    <= '0;
      r_ctrl    <= 4'b0000;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      if ((r_state == IDLE) && w_accept) begin
        r_src1 <= req_src1_i;
        r_src2 <= req_src2_i;
        r_ctrl <= w_dec_ctrl;
        r_cnt  <= CNT_LOAD;
        if (w_dec_illegal) begin
          r_result  <= '0;
          r_zero    <= 1'b1;
          r_illegal <= 1'b1;
        end
      end
      if (r_state == EXEC) begin
        if (w_cnt_done) begin
          r_result  <= alu_result_i;
          r_zero    <= alu_zero_i;
          r_illegal <= 1'b0;
        end else begin
          r_cnt <= r_cnt - EW'(1);
        end
      end
      if (w_rsp_done) r_count <= r_count + CNT_W'(1);
    end
  end

  assign req_ready_o   = r_ready;
  assign alu_src1_o    = r_src1;
  assign alu_src2_o    = r_src2;
  assign alu_ctrl_o    = r_ctrl;
  assign rsp_valid_o   = (r_state == RESP);
  assign rsp_result_o  = r_result;
  assign rsp_zero_o    = r_zero;
  assign rsp_illegal_o = r_illegal;
  assign op_count_o    = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with EXEC_CYCLES=1 driven from a
// vector table, a second with EXEC_CYCLES=3 for multi-cycle hold and latency.
module tb_alu_op_sequencer;

  function automatic logic [31:0] aluModel(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstN;

  logic        reqValid1, reqReady1, rspValid1, rspReady1, rspZero1, rspIllegal1, aluZero1;
  logic [1:0]  reqAluop1;
  logic [5:0]  reqFunct1;
  logic [31:0] reqA1, reqB1, aluA1, aluB1, aluRes1, rspResult1;
  logic [3:0]  aluCtrl1;
  logic [15:0] opCount1;

  logic        reqValid3, reqReady3, rspValid3, rspReady3, rspZero3, rspIllegal3, aluZero3;
  logic [1:0]  reqAluop3;
  logic [5:0]  reqFunct3;
  logic [31:0] reqA3, reqB3, aluA3, aluB3, aluRes3, rspResult3;
  logic [3:0]  aluCtrl3;
  logic [15:0] opCount3;

  assign aluRes1  = aluModel(aluCtrl1, aluA1, aluB1);
  assign aluZero1 = (aluRes1 == 32'd0);
  assign aluRes3  = aluModel(aluCtrl3, aluA3, aluB3);
  assign aluZero3 = (aluRes3 == 32'd0);

  alu_op_sequencer #(.WIDTH(32), .EXEC_CYCLES(1), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rstN),
    .req_valid_i(reqValid1), .req_ready_o(reqReady1), .req_aluop_i(reqAluop1),
    .req_funct_i(reqFunct1), .req_src1_i(reqA1), .req_src2_i(reqB1),
    .alu_src1_o(aluA1), .alu_src2_o(aluB1), .alu_ctrl_o(aluCtrl1),
    .alu_result_i(aluRes1), .alu_zero_i(aluZero1),
    .rsp_valid_o(rspValid1), .rsp_ready_i(rspReady1), .rsp_result_o(rspResult1),
    .rsp_zero_o(rspZero1), .rsp_illegal_o(rspIllegal1), .op_count_o(opCount1)
  );

  alu_op_sequencer #(.WIDTH(32), .EXEC_CYCLES(3), .CNT_W(16)) dut3 (
    .clk_i(clk), .rst_i(rstN),
    .req_valid_i(reqValid3), .req_ready_o(reqReady3), .req_aluop_i(reqAluop3),
    .req_funct_i(reqFunct3), .req_src1_i(reqA3), .req_src2_i(reqB3),
    .alu_src1_o(aluA3), .alu_src2_o(aluB3), .alu_ctrl_o(aluCtrl3),
    .alu_result_i(aluRes3), .alu_zero_i(aluZero3),
    .rsp_valid_o(rspValid3), .rsp_ready_i(rspReady3), .rsp_result_o(rspResult3),
    .rsp_zero_o(rspZero3), .rsp_illegal_o(rspIllegal3), .op_count_o(opCount3)
  );

  typedef struct {
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[10];
  int total = 0;
  int bad = 0;
  int expCount1 = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitReady1();
    int n = 0;
    while (!reqReady1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reqReady1", reqReady1, 1'b1);
  endtask

  // Full request/response transaction on dut1; latency counts the accepting edge as 1.
  task automatic applyStimulus(input vec_t v);
    int edges;
    waitReady1();
    reqValid1 = 1'b1;
    reqAluop1 = v.aluop;
    reqFunct1 = v.funct;
    reqA1     = v.a;
    reqB1     = v.b;
    @(posedge clk); #1;
    reqValid1 = 1'b0;
    reqA1     = $urandom;
    reqB1     = $urandom;
    reqAluop1 = 2'($urandom_range(0, 3));
    reqFunct1 = 6'($urandom_range(0, 63));
    edges = 1;
    while (!rspValid1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("latency", edges, v.lat);
    checkOutput("aluCtrl", aluCtrl1, v.ctrl);
    checkOutput("aluSrc1", aluA1, v.a);
    checkOutput("aluSrc2", aluB1, v.b);
    checkOutput("rspResult", rspResult1, v.res);
    checkOutput("rspZero", rspZero1, v.zero);
    checkOutput("rspIllegal", rspIllegal1, v.ill);
    checkOutput("reqReadyBusy", reqReady1, 1'b0);
    rspReady1 = 1'b1;
    @(posedge clk); #1;
    rspReady1 = 1'b0;
    expCount1++;
    checkOutput("rspValidDrop", rspValid1, 1'b0);
    checkOutput("opCount", opCount1, expCount1);
    checkOutput("aluCtrlHeldIdle", aluCtrl1, v.ctrl);
  endtask

  task automatic runE3(input logic [1:0] aluop, input logic [5:0] funct, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] ctrl, input logic [31:0] res);
    int n = 0;
    while (!reqReady3 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("e3Ready", reqReady3, 1'b1);
    reqValid3 = 1'b1;
    reqAluop3 = aluop;
    reqFunct3 = funct;
    reqA3     = a;
    reqB3     = b;
    @(posedge clk); #1;
    reqValid3 = 1'b0;
    reqA3     = $urandom;
    reqB3     = $urandom;
    reqAluop3 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      checkOutput("e3ValidEarly", rspValid3, 1'b0);
      checkOutput("e3CtrlHold", aluCtrl3, ctrl);
      checkOutput("e3Src1Hold", aluA3, a);
      checkOutput("e3Src2Hold", aluB3, b);
      @(posedge clk); #1;
    end
    checkOutput("e3ValidOnTime", rspValid3, 1'b1);
    checkOutput("e3Result", rspResult3, res);
    checkOutput("e3Illegal", rspIllegal3, 1'b0);
    rspReady3 = 1'b1;
    @(posedge clk); #1;
    rspReady3 = 1'b0;
    checkOutput("e3ValidDrop", rspValid3, 1'b0);
  endtask

  initial begin
    int edges;
    vec_t v;
    rstN = 1'b0;
    reqValid1 = 1'b0; reqAluop1 = 2'b00; reqFunct1 = 6'd0; reqA1 = 32'd0; reqB1 = 32'd0;
    rspReady1 = 1'b0;
    reqValid3 = 1'b0; reqAluop3 = 2'b00; reqFunct3 = 6'd0; reqA3 = 32'd0; reqB3 = 32'd0;
    rspReady3 = 1'b0;

    vecs[0] = '{2'b10, 6'b100000, 32'd5,         32'd7,         4'b0010, 32'd12,        1'b0, 1'b0, 2};
    vecs[1] = '{2'b01, 6'b101010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0110, 32'd0,         1'b1, 1'b0, 2};
    vecs[2] = '{2'b10, 6'b000000, 32'd1,         32'd2,         4'b0010, 32'd0,         1'b1, 1'b1, 1};
    vecs[3] = '{2'b11, 6'b100000, 32'd4,         32'd6,         4'b0010, 32'd0,         1'b1, 1'b1, 1};
    vecs[4] = '{2'b10, 6'b100010, 32'd10,        32'd3,         4'b0110, 32'd7,         1'b0, 1'b0, 2};
    vecs[5] = '{2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0000, 32'h0000_00F0, 1'b0, 1'b0, 2};
    vecs[6] = '{2'b10, 6'b100101, 32'hF000_0000, 32'h0000_000F, 4'b0001, 32'hF000_000F, 1'b0, 1'b0, 2};
    vecs[7] = '{2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1,         4'b0111, 32'd1,         1'b0, 1'b0, 2};
    vecs[8] = '{2'b00, 6'b100100, 32'hFFFF_FFFF, 32'd1,         4'b0010, 32'd0,         1'b1, 1'b0, 2};
    vecs[9] = '{2'b10, 6'b100001, 32'd9,         32'd9,         4'b0010, 32'd0,         1'b1, 1'b1, 1};

    #12;
    checkOutput("rstReqReady", reqReady1, 1'b0);
    checkOutput("rstRspValid", rspValid1, 1'b0);
    checkOutput("rstAluCtrl", aluCtrl1, 4'b0000);
    checkOutput("rstAluSrc1", aluA1, 32'd0);
    checkOutput("rstAluSrc2", aluB1, 32'd0);
    checkOutput("rstResult", rspResult1, 32'd0);
    checkOutput("rstZero", rspZero1, 1'b0);
    checkOutput("rstIllegal", rspIllegal1, 1'b0);
    checkOutput("rstCount", opCount1, 16'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("readyAtRelease", reqReady1, 1'b0);
    @(posedge clk); #1;
    checkOutput("readyFirstClock", reqReady1, 1'b1);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Backpressure: slt 3<9 held for 10 clocks with stray request traffic ignored.
    waitReady1();
    reqValid1 = 1'b1; reqAluop1 = 2'b10; reqFunct1 = 6'b101010; reqA1 = 32'd3; reqB1 = 32'd9;
    @(posedge clk); #1;
    reqAluop1 = 2'b00; reqA1 = 32'd100; reqB1 = 32'd200;
    edges = 1;
    while (!rspValid1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("bpLatency", edges, 2);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bpValid", rspValid1, 1'b1);
      checkOutput("bpResult", rspResult1, 32'd1);
      checkOutput("bpReqReady", reqReady1, 1'b0);
      checkOutput("bpSrc1", aluA1, 32'd3);
      checkOutput("bpCtrl", aluCtrl1, 4'b0111);
      @(posedge clk); #1;
    end
    reqValid1 = 1'b0;
    rspReady1 = 1'b1;
    @(posedge clk); #1;
    rspReady1 = 1'b0;
    expCount1++;
    checkOutput("bpCount", opCount1, expCount1);
    checkOutput("bpValidDrop", rspValid1, 1'b0);

    runE3(2'b10, 6'b100100, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'b0000, 32'h0F00_0F00);
    runE3(2'b10, 6'b100101, 32'h1200_0034, 32'h0056_7800, 4'b0001, 32'h1256_7834);
    checkOutput("e3Count", opCount3, 16'd2);

    // Reset while the add is in EXEC: everything clears and no response follows.
    waitReady1();
    reqValid1 = 1'b1; reqAluop1 = 2'b00; reqA1 = 32'd100; reqB1 = 32'd23;
    @(posedge clk); #1;
    reqValid1 = 1'b0;
    rstN = 1'b0;
    #1;
    checkOutput("midRstSrc1", aluA1, 32'd0);
    checkOutput("midRstCtrl", aluCtrl1, 4'b0000);
    checkOutput("midRstCount", opCount1, 16'd0);
    checkOutput("midRstValid", rspValid1, 1'b0);
    checkOutput("midRstResult", rspResult1, 32'd0);
    checkOutput("midRstReady", reqReady1, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    expCount1 = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("postRstNoRsp", rspValid1, 1'b0);
    end
    v = '{2'b00, 6'b000000, 32'd40, 32'd2, 4'b0010, 32'd42, 1'b0, 1'b0, 2};
    applyStimulus(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
